// File: rtl/ex_muldiv_sequencer.sv
// EX-stage multi-cycle multiply / divide / modulus sequencer.
// 32-iteration shift-add multiplier and restoring divider sharing one FSM.
`timescale 1ns/1ps

module ex_muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        isMul,
    input  logic        isDiv,
    input  logic        isMod,
    input  logic        flush,
    input  logic [31:0] Operand_EX_A,
    input  logic [31:0] Operand_EX_B,
    output logic        stall,
    output logic        done,
    output logic [31:0] MD_Result,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_DIV = 2'd1,
        OP_MOD = 2'd2
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;   // multiplier, or divisor for DIV/MOD
    logic [31:0] acc_q, acc_d;         // product accumulator, or dividend/quotient
    logic [31:0] rem_q, rem_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        any_op_s;
    logic        accept_s;
    op_t         sel_op_s;
    logic [31:0] mul_acc_nxt_s;
    logic [32:0] rem_shift_s;
    logic [32:0] rem_sub_s;
    logic        rem_ge_s;
    logic [31:0] rem_nxt_s;
    logic [31:0] quo_nxt_s;

    // Acceptance decode and op priority (mul > div > mod)
    always_comb begin
        any_op_s = isMul | isDiv | isMod;
        accept_s = (state_q == IDLE) & start & any_op_s & ~flush;
        if (isMul) begin
            sel_op_s = OP_MUL;
        end else if (isDiv) begin
            sel_op_s = OP_DIV;
        end else begin
            sel_op_s = OP_MOD;
        end
    end

    // One iteration of each engine; the borrow out of the 33-bit subtract is the compare
    always_comb begin
        mul_acc_nxt_s = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
        rem_shift_s   = {rem_q, acc_q[31]};
        rem_sub_s     = rem_shift_s - {1'b0, mplier_q};
        rem_ge_s      = ~rem_sub_s[32];
        rem_nxt_s     = rem_ge_s ? rem_sub_s[31:0] : rem_shift_s[31:0];
        quo_nxt_s     = {acc_q[30:0], rem_ge_s};
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    op_d  = sel_op_s;
                    cnt_d = 5'd0;
                    dbz_d = 1'b0;
                    if ((sel_op_s != OP_MUL) && (Operand_EX_B == 32'd0)) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        dbz_d    = 1'b1;
                        result_d = (sel_op_s == OP_DIV) ? 32'hFFFF_FFFF : Operand_EX_A;
                    end else begin
                        state_d  = RUN;
                        mcand_d  = Operand_EX_A;
                        mplier_d = Operand_EX_B;
                        acc_d    = (sel_op_s == OP_MUL) ? 32'd0 : Operand_EX_A;
                        rem_d    = 32'd0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (op_q == OP_MUL) begin
                    acc_d    = mul_acc_nxt_s;
                    mcand_d  = {mcand_q[30:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[31:1]};
                end else begin
                    acc_d = quo_nxt_s;
                    rem_d = rem_nxt_s;
                end
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    case (op_q)
                        OP_MUL:  result_d = mul_acc_nxt_s;
                        OP_DIV:  result_d = quo_nxt_s;
                        OP_MOD:  result_d = rem_nxt_s;
                        default: result_d = result_q;
                    endcase
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush abandons the operation without publishing anything
        if (flush) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
            dbz_d    = dbz_q;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= 5'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
            rem_q    <= 32'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign stall       = accept_s | (state_q == RUN);
    assign done        = done_q;
    assign MD_Result   = result_q;
    assign div_by_zero = dbz_q;

endmodule
